// File: rtl/pwm_defines.sv
`default_nettype none
// ============================================================================
// Module   : pwm_defines
// Purpose  : Shared constants for the PWM pulse generators: FSM encodings,
//            default counter width and the packed-channel slice macro.
// Revision : 1.0 - initial multi-channel release
// ============================================================================

`ifndef PWM_DEFINES_SLICE
`define PWM_DEFINES_SLICE
// Select channel k (width w) out of a packed per-channel bus.
`define PWM_SLICE(k, w) (k)*(w) +: (w)
`endif

package pwm_defines;

  localparam int DEFAULT_BITWIDTH = 10;

  localparam int STATE_W = 1;
  localparam logic [STATE_W-1:0] STATE_IDLE = 1'b0;
  localparam logic [STATE_W-1:0] STATE_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pulse_channel.sv
`default_nettype none
// ============================================================================
// Module   : pulse_channel
// Purpose  : One pulse output. Holds the active rising/falling ticks and
//            polarity, the raw pulse state and the registered output.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module pulse_channel
  import pwm_defines::*;
#(
  parameter int bitwidth = DEFAULT_BITWIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [bitwidth-1:0] counter_value,
  input  logic                run,
  input  logic                clear,
  input  logic                apply,
  input  logic [bitwidth-1:0] shadow_rising,
  input  logic [bitwidth-1:0] shadow_falling,
  input  logic                shadow_polarity,
  output logic                generated_signal
);

  logic [bitwidth-1:0] r_rising;
  logic [bitwidth-1:0] r_falling;
  logic                r_polarity;
  logic                r_raw;
  logic                r_out;
  logic                w_raw_next;
  logic                w_polarity_next;

  // Raw state follows the pre-edge counter against the currently active
  // ticks; falling is tested first so that equal ticks leave the pulse low.
  always_comb begin
    w_raw_next      = r_raw;
    w_polarity_next = apply ? shadow_polarity : r_polarity;
    if (clear) begin
      w_raw_next = 1'b0;
    end else if (run) begin
      if (counter_value == r_falling) begin
        w_raw_next = 1'b0;
      end else if (counter_value == r_rising) begin
        w_raw_next = 1'b1;
      end
    end
  end

  // Active settings, raw state and polarity-corrected output share one edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rising   <= '0;
      r_falling  <= '0;
      r_polarity <= 1'b0;
      r_raw      <= 1'b0;
      r_out      <= 1'b0;
    end else begin
      if (apply) begin
        r_rising  <= shadow_rising;
        r_falling <= shadow_falling;
      end
      r_polarity <= w_polarity_next;
      r_raw      <= w_raw_next;
      r_out      <= w_raw_next ^ w_polarity_next;
    end
  end

  assign generated_signal = r_out;

endmodule

`default_nettype wire

// File: rtl/pulse_multichannel.sv
`default_nettype none
// ============================================================================
// Module   : pulse_multichannel
// Purpose  : Multi-channel pulse generator. Owns the period counter, the
//            IDLE/RUN FSM, the shadow registers and the update handshake;
//            each output is produced by a pulse_channel instance.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module pulse_multichannel
  import pwm_defines::*;
#(
  parameter int bitwidth = DEFAULT_BITWIDTH,
  parameter int channels = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [bitwidth-1:0]          period,
  input  logic [channels*bitwidth-1:0] rising_edges,
  input  logic [channels*bitwidth-1:0] falling_edges,
  input  logic [channels-1:0]          polarity,
  input  logic                         update_request,
  output logic                         update_acknowledge,
  output logic [bitwidth-1:0]          counter_value,
  output logic                         period_start,
  output logic [channels-1:0]          generated_signals
);

  localparam logic [bitwidth-1:0] c_one = bitwidth'(1);

  logic [STATE_W-1:0]          r_state;
  logic [STATE_W-1:0]          w_state_next;
  logic [bitwidth-1:0]         r_counter;
  logic [bitwidth-1:0]         w_counter_next;
  logic [bitwidth-1:0]         r_period;
  logic [bitwidth-1:0]         r_shadow_period;
  logic [channels*bitwidth-1:0] r_shadow_rising;
  logic [channels*bitwidth-1:0] r_shadow_falling;
  logic [channels-1:0]         r_shadow_polarity;
  logic                        r_pending;
  logic                        r_ack;
  logic                        w_run;
  logic                        w_clear;
  logic                        w_period_start;
  logic                        w_wrap;
  logic                        w_apply;

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= STATE_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: enable alone decides between IDLE and RUN
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STATE_IDLE: if (enable)  w_state_next = STATE_RUN;
      STATE_RUN:  if (!enable) w_state_next = STATE_IDLE;
      default:    w_state_next = STATE_IDLE;
    endcase
  end

  // FSM outputs: counting edge, leave-RUN clear and period start flag
  always_comb begin
    w_run          = 1'b0;
    w_clear        = 1'b0;
    w_period_start = 1'b0;
    if (r_state == STATE_RUN) begin
      w_run          = enable;
      w_clear        = !enable;
      w_period_start = (r_counter == '0);
    end
  end

  // A wrap edge is a counting edge at the active period; the shadow is
  // applied there, or on any IDLE edge once something is pending.
  assign w_wrap  = w_run && (r_counter == r_period);
  assign w_apply = r_pending && ((r_state == STATE_IDLE) || w_wrap);

  // Counter next value: increment, wrap to 0, or park at 0 outside RUN
  always_comb begin
    w_counter_next = '0;
    if (w_run && !w_wrap) begin
      w_counter_next = r_counter + c_one;
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_counter <= '0;
    end else begin
      r_counter <= w_counter_next;
    end
  end

  // Shadow capture, pending flag, active period and acknowledge pulse.
  // A request on an apply edge re-arms pending for the following boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shadow_period   <= '0;
      r_shadow_rising   <= '0;
      r_shadow_falling  <= '0;
      r_shadow_polarity <= '0;
      r_pending         <= 1'b0;
      r_period          <= '0;
      r_ack             <= 1'b0;
    end else begin
      if (update_request) begin
        r_shadow_period   <= period;
        r_shadow_rising   <= rising_edges;
        r_shadow_falling  <= falling_edges;
        r_shadow_polarity <= polarity;
        r_pending         <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      if (w_apply) begin
        r_period <= r_shadow_period;
      end
      r_ack <= w_apply;
    end
  end

  generate
    for (genvar k = 0; k < channels; k++) begin : g_channel
      pulse_channel #(
        .bitwidth(bitwidth)
      ) u_channel (
        .clock            (clock),
        .reset            (reset),
        .counter_value    (r_counter),
        .run              (w_run),
        .clear            (w_clear),
        .apply            (w_apply),
        .shadow_rising    (r_shadow_rising[`PWM_SLICE(k, bitwidth)]),
        .shadow_falling   (r_shadow_falling[`PWM_SLICE(k, bitwidth)]),
        .shadow_polarity  (r_shadow_polarity[k]),
        .generated_signal (generated_signals[k])
      );
    end
  endgenerate

  assign update_acknowledge = r_ack;
  assign counter_value      = r_counter;
  assign period_start       = w_period_start;

endmodule

`default_nettype wire

// File: tb/tb_pulse_multichannel.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_multichannel
// Purpose  : Self-checking bench for pulse_multichannel (10 bits, 2 channels)
//            with directed scenarios and randomized traffic against a
//            behavioural reference model.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module tb_pulse_multichannel;

  localparam int BW = 10;
  localparam int CH = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic [BW-1:0]  period = '0;
  logic [CH*BW-1:0] rising_edges = '0;
  logic [CH*BW-1:0] falling_edges = '0;
  logic [CH-1:0]  polarity = '0;
  logic           update_request = 1'b0;
  logic           update_acknowledge;
  logic [BW-1:0]  counter_value;
  logic           period_start;
  logic [CH-1:0]  generated_signals;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pulse_multichannel #(.bitwidth(BW), .channels(CH)) dut (
    .clock              (clock),
    .reset              (reset),
    .enable             (enable),
    .period             (period),
    .rising_edges       (rising_edges),
    .falling_edges      (falling_edges),
    .polarity           (polarity),
    .update_request     (update_request),
    .update_acknowledge (update_acknowledge),
    .counter_value      (counter_value),
    .period_start       (period_start),
    .generated_signals  (generated_signals)
  );

  // ---------------- reference model (plain integers) ----------------
  bit m_run, m_pend, m_ack;
  int m_cnt, m_per, s_per;
  int m_r[CH], m_f[CH], s_r[CH], s_f[CH];
  bit m_p[CH], m_raw[CH], s_p[CH];

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_ack = 0; m_cnt = 0; m_per = 0; s_per = 0;
    for (int k = 0; k < CH; k++) begin
      m_r[k] = 0; m_f[k] = 0; s_r[k] = 0; s_f[k] = 0;
      m_p[k] = 0; m_raw[k] = 0; s_p[k] = 0;
    end
  endtask

  // One clock edge: everything is decided from pre-edge values.
  task automatic model_step();
    bit wrap, apply;
    wrap  = m_run && enable && (m_cnt == m_per);
    apply = m_pend && (!m_run || wrap);
    for (int k = 0; k < CH; k++) begin
      if (m_run) begin
        if (!enable)               m_raw[k] = 0;
        else if (m_cnt == m_f[k])  m_raw[k] = 0;
        else if (m_cnt == m_r[k])  m_raw[k] = 1;
      end
    end
    if (m_run) m_cnt = (!enable || wrap) ? 0 : m_cnt + 1;
    if (apply) begin
      m_per = s_per;
      for (int k = 0; k < CH; k++) begin
        m_r[k] = s_r[k]; m_f[k] = s_f[k]; m_p[k] = s_p[k];
      end
    end
    if (update_request) begin
      s_per = int'(period);
      for (int k = 0; k < CH; k++) begin
        s_r[k] = int'(rising_edges[k*BW +: BW]);
        s_f[k] = int'(falling_edges[k*BW +: BW]);
        s_p[k] = polarity[k];
      end
      m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
    m_ack = apply;
    m_run = enable;
  endtask

  function automatic logic [BW+3:0] exp_vec();
    logic [CH-1:0] g;
    for (int k = 0; k < CH; k++) g[k] = m_raw[k] ^ m_p[k];
    return {m_ack, BW'(m_cnt), (m_run && m_cnt == 0), g};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_stage(input int per, input int r0, input int f0, input bit p0,
                           input int r1, input int f1, input bit p1);
    period        = BW'(per);
    rising_edges  = {BW'(r1), BW'(r0)};
    falling_edges = {BW'(f1), BW'(f0)};
    polarity      = {p1, p0};
  endtask

  task automatic wait_counter(input int target);
    int guard = 0;
    while (counter_value != BW'(target) && guard < 60) begin
      tick();
      guard++;
    end
    n_checks++;
    if (counter_value != BW'(target)) begin
      n_fail++;
      $display("FAIL wait_counter: counter_value=%0d required=%0d within 60 cycles", counter_value, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    n_checks++;
    if ({update_acknowledge, counter_value, period_start, generated_signals} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b cnt=%0d ps=%b gen=%b required all 0",
               update_acknowledge, counter_value, period_start, generated_signals);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({update_acknowledge, counter_value, period_start, generated_signals} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got cnt=%0d ps=%b gen=%b required 0", counter_value, period_start, generated_signals);
    end
  endtask

  task automatic test_idle_apply_and_waveform();
    set_stage(9, 2, 5, 0, 7, 1, 1);
    update_request = 1'b1;
    tick();
    update_request = 1'b0;
    n_checks++;
    if (update_acknowledge !== 1'b0 || generated_signals !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_capture: got ack=%b gen=%b required ack=0 gen=00", update_acknowledge, generated_signals);
    end
    tick();
    n_checks++;
    if (update_acknowledge !== 1'b1 || generated_signals !== 2'b10 || counter_value !== '0) begin
      n_fail++;
      $display("FAIL idle_apply: got ack=%b gen=%b cnt=%0d required ack=1 gen=10 cnt=0",
               update_acknowledge, generated_signals, counter_value);
    end
    tick();
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [CH-1:0] cf;
      int c;
      tick();
      n_checks++;
      if ({update_acknowledge, counter_value, period_start, generated_signals} !== exp_vec()) begin
        n_fail++;
        $display("FAIL waveform_model cycle %0d: got %h required %h", i,
                 {update_acknowledge, counter_value, period_start, generated_signals}, exp_vec());
      end
      if (i >= 12) begin
        c = int'(counter_value);
        cf[0] = (c >= 3 && c <= 5);
        cf[1] = !(c >= 8 || c <= 1);
        n_checks++;
        if (generated_signals !== cf || period_start !== (c == 0)) begin
          n_fail++;
          $display("FAIL waveform_shape cnt=%0d: got gen=%b ps=%b required gen=%b ps=%b",
                   c, generated_signals, period_start, cf, (c == 0));
        end
      end
    end
  endtask

  task automatic test_update_midrun();
    int acks = 0;
    int ack_cnt = -1;
    wait_counter(3);
    set_stage(4, 1, 3, 0, 7, 1, 1);
    update_request = 1'b1;
    tick();
    update_request = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if ({update_acknowledge, counter_value, period_start, generated_signals} !== exp_vec()) begin
        n_fail++;
        $display("FAIL midrun_model cycle %0d: got %h required %h", i,
                 {update_acknowledge, counter_value, period_start, generated_signals}, exp_vec());
      end
      if (update_acknowledge) begin
        acks++;
        ack_cnt = int'(counter_value);
        n_checks++;
        if (i != 5) begin
          n_fail++;
          $display("FAIL midrun_ack_time: got cycle %0d required cycle 5", i);
        end
      end
      if (i >= 12) begin
        int c;
        c = int'(counter_value);
        n_checks++;
        if (generated_signals !== {1'b1, (c >= 2 && c <= 3)} || c > 4) begin
          n_fail++;
          $display("FAIL midrun_shape cnt=%0d: got gen=%b required gen=%b", c, generated_signals,
                   {1'b1, (c >= 2 && c <= 3)});
        end
      end
    end
    n_checks++;
    if (acks != 1 || ack_cnt != 0) begin
      n_fail++;
      $display("FAIL midrun_ack_count: got %0d acks at cnt %0d required 1 ack at cnt 0", acks, ack_cnt);
    end
  endtask

  task automatic test_wrap_request();
    int ack_at = -1;
    wait_counter(4);
    set_stage(9, 2, 5, 0, 7, 1, 1);
    update_request = 1'b1;
    tick();
    update_request = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++;
      if ({update_acknowledge, counter_value, period_start, generated_signals} !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrapreq_model cycle %0d: got %h required %h", i,
                 {update_acknowledge, counter_value, period_start, generated_signals}, exp_vec());
      end
      if (update_acknowledge && ack_at < 0) ack_at = i;
    end
    n_checks++;
    if (ack_at != 5) begin
      n_fail++;
      $display("FAIL wrapreq_ack_delay: got ack after %0d edges required 5", ack_at);
    end
  endtask

  task automatic test_corner_ticks();
    bit seen = 0;
    wait_counter(5);
    set_stage(9, 4, 4, 0, 12, 13, 1);
    update_request = 1'b1;
    tick();
    update_request = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if ({update_acknowledge, counter_value, period_start, generated_signals} !== exp_vec()) begin
        n_fail++;
        $display("FAIL corner_model cycle %0d: got %h required %h", i,
                 {update_acknowledge, counter_value, period_start, generated_signals}, exp_vec());
      end
      if (update_acknowledge) seen = 1;
      if (seen) begin
        n_checks++;
        if (generated_signals !== 2'b00) begin
          n_fail++;
          $display("FAIL corner_hold: got gen=%b required 00", generated_signals);
        end
      end
    end
  endtask

  task automatic test_disable();
    int guard = 0;
    wait_counter(5);
    set_stage(9, 2, 8, 1, 7, 1, 1);
    update_request = 1'b1;
    tick();
    update_request = 1'b0;
    while (!update_acknowledge && guard < 30) begin tick(); guard++; end
    wait_counter(6);
    n_checks++;
    if (generated_signals[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_pre: got gen0=%b required 0 (raw high, inverted)", generated_signals[0]);
    end
    enable = 1'b0;
    tick();
    n_checks++;
    if (counter_value !== '0 || period_start !== 1'b0 || generated_signals !== 2'b11) begin
      n_fail++;
      $display("FAIL disable_idle: got cnt=%0d ps=%b gen=%b required cnt=0 ps=0 gen=11",
               counter_value, period_start, generated_signals);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({update_acknowledge, counter_value, period_start, generated_signals} !== exp_vec()) begin
        n_fail++;
        $display("FAIL disable_model cycle %0d: got %h required %h", i,
                 {update_acknowledge, counter_value, period_start, generated_signals}, exp_vec());
      end
    end
    enable = 1'b1;
    tick();
    n_checks++;
    if (counter_value !== '0 || period_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reenable_first: got cnt=%0d ps=%b required cnt=0 ps=1", counter_value, period_start);
    end
    tick();
    n_checks++;
    if (counter_value !== BW'(1) || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reenable_second: got cnt=%0d ps=%b required cnt=1 ps=0", counter_value, period_start);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      enable         = ($urandom_range(0, 19) != 0);
      update_request = ($urandom_range(0, 7) == 0);
      set_stage($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14), 1'($urandom),
                $urandom_range(0, 14), $urandom_range(0, 14), 1'($urandom));
      tick();
      n_checks++;
      if ({update_acknowledge, counter_value, period_start, generated_signals} !== exp_vec()) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random cycle %0d: got %h required %h", i,
                   {update_acknowledge, counter_value, period_start, generated_signals}, exp_vec());
        bad++;
      end
    end
    update_request = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    enable = 1'b1;
    set_stage(9, 2, 8, 0, 7, 1, 1);
    update_request = 1'b1;
    tick();
    update_request = 1'b0;
    while (!update_acknowledge && guard < 30) begin tick(); guard++; end
    wait_counter(4);
    update_request = 1'b1;
    tick();
    update_request = 1'b0;
    n_checks++;
    if (counter_value !== BW'(5) || generated_signals[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got cnt=%0d gen0=%b required cnt=5 gen0=1", counter_value, generated_signals[0]);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({update_acknowledge, counter_value, period_start, generated_signals} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got ack=%b cnt=%0d ps=%b gen=%b required all 0",
               update_acknowledge, counter_value, period_start, generated_signals);
    end
    model_reset();
    @(posedge clock); #1;
    reset  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (update_acknowledge !== 1'b0 || generated_signals !== 2'b00) begin
        n_fail++;
        $display("FAIL async_discard cycle %0d: got ack=%b gen=%b required ack=0 gen=00",
                 i, update_acknowledge, generated_signals);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (counter_value !== '0 || period_start !== 1'b1 ||
          {update_acknowledge, counter_value, period_start, generated_signals} !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_period0 cycle %0d: got cnt=%0d ps=%b required cnt=0 ps=1",
                 i, counter_value, period_start);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_apply_and_waveform();
    test_update_midrun();
    test_wrap_request();
    test_corner_ticks();
    test_disable();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
